// File: rtl/cam_alloc_ctrl.sv
// Sequencing controller for a single CAM: duplicate-free insert, invalidate and flush.
// Optional macro CAM_ALLOC_NRU_EN replaces round-robin victim choice with not-recently-used.
module cam_alloc_ctrl #(
    parameter int NUM_ENTRIES = 2,
    parameter int KEY_WIDTH   = 32,
    parameter int INDEX_WIDTH = $clog2(NUM_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [KEY_WIDTH-1:0]   req_key,
    output logic                   resp_valid,
    output logic [INDEX_WIDTH-1:0] resp_idx,
    output logic                   resp_hit,
    output logic                   resp_evict,
    output logic [KEY_WIDTH-1:0]   cam_lookup_key,
    input  logic                   cam_lookup_hit,
    input  logic [INDEX_WIDTH-1:0] cam_lookup_idx,
    output logic                   cam_update_en,
    output logic [KEY_WIDTH-1:0]   cam_update_key,
    output logic [INDEX_WIDTH-1:0] cam_update_idx,
    output logic                   cam_update_valid,
    input  logic                   touch_en,
    input  logic [INDEX_WIDTH-1:0] touch_idx
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_ENTRIES - 1);
    localparam logic [NUM_ENTRIES-1:0] ONE_HOT0 = NUM_ENTRIES'(1);

    state_t                 r_state;
    logic                   r_ready;
    logic [1:0]             r_op;
    logic [KEY_WIDTH-1:0]   r_key;
    logic [NUM_ENTRIES-1:0] r_valid;
    logic [INDEX_WIDTH-1:0] r_flush_cnt;
    logic                   r_resp_valid;
    logic [INDEX_WIDTH-1:0] r_resp_idx;
    logic                   r_resp_hit;
    logic                   r_resp_evict;

    logic                   w_free_any;
    logic [INDEX_WIDTH-1:0] w_free_idx;
    logic [INDEX_WIDTH-1:0] w_victim_idx;
    logic [INDEX_WIDTH-1:0] w_tgt_idx;
    logic                   w_evict;
    logic                   w_upd_en;
    logic [KEY_WIDTH-1:0]   w_upd_key;
    logic [INDEX_WIDTH-1:0] w_upd_idx;
    logic                   w_upd_valid;
    logic                   w_is_insert;
    logic                   w_is_inval_hit;

    assign w_is_insert    = (r_state == ST_EXEC) && (r_op == 2'd0);
    assign w_is_inval_hit = (r_state == ST_EXEC) && (r_op == 2'd1) && cam_lookup_hit;

`ifdef CAM_ALLOC_NRU_EN
    logic [NUM_ENTRIES-1:0] r_used;
    logic [NUM_ENTRIES-1:0] w_used_set;
    logic [NUM_ENTRIES-1:0] w_used_clr;
    logic [NUM_ENTRIES-1:0] w_used_nxt;

    // Victim is the lowest slot not used since the last saturation.
    always_comb begin
        w_victim_idx = {INDEX_WIDTH{1'b0}};
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!r_used[i]) begin
                w_victim_idx = INDEX_WIDTH'(i);
            end else begin
                w_victim_idx = w_victim_idx;
            end
        end
    end

    // Set/clear masks; saturation keeps only the bits being set this cycle.
    always_comb begin
        w_used_set = (touch_en ? (ONE_HOT0 << touch_idx) : {NUM_ENTRIES{1'b0}})
                   | (w_is_insert ? (ONE_HOT0 << w_tgt_idx) : {NUM_ENTRIES{1'b0}});
        w_used_clr = w_is_inval_hit ? (ONE_HOT0 << cam_lookup_idx) : {NUM_ENTRIES{1'b0}};
        w_used_nxt = (r_used & ~w_used_clr) | w_used_set;
        if (&w_used_nxt) begin
            w_used_nxt = w_used_set;
        end else begin
            w_used_nxt = w_used_nxt;
        end
    end

    // Usage tracking; a completed flush starts every slot as unused.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_used <= {NUM_ENTRIES{1'b0}};
        end else if (r_state == ST_FLUSH) begin
            r_used <= {NUM_ENTRIES{1'b0}};
        end else begin
            r_used <= w_used_nxt;
        end
    end
`else
    logic [INDEX_WIDTH-1:0] r_victim_ptr;
    logic                   w_unused_touch;

    assign w_unused_touch = ^{touch_en, touch_idx};
    assign w_victim_idx   = r_victim_ptr;

    // Round-robin pointer moves only when an eviction actually happens.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_victim_ptr <= {INDEX_WIDTH{1'b0}};
        end else if (r_state == ST_FLUSH) begin
            r_victim_ptr <= {INDEX_WIDTH{1'b0}};
        end else if (w_is_insert && w_evict) begin
            r_victim_ptr <= (r_victim_ptr == LAST_IDX) ? {INDEX_WIDTH{1'b0}} : r_victim_ptr + 1'b1;
        end else begin
            r_victim_ptr <= r_victim_ptr;
        end
    end
`endif

    // Lowest free slot from the shadow valid bits.
    always_comb begin
        w_free_any = 1'b0;
        w_free_idx = {INDEX_WIDTH{1'b0}};
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_any = 1'b1;
                w_free_idx = INDEX_WIDTH'(i);
            end else begin
                w_free_idx = w_free_idx;
            end
        end
    end

    // Insert target priority: existing slot, lowest free slot, victim.
    always_comb begin
        w_evict = 1'b0;
        if (cam_lookup_hit) begin
            w_tgt_idx = cam_lookup_idx;
        end else if (w_free_any) begin
            w_tgt_idx = w_free_idx;
        end else begin
            w_tgt_idx = w_victim_idx;
            w_evict   = 1'b1;
        end
    end

    // CAM update port; depends on the same-cycle lookup result during EXEC.
    always_comb begin
        w_upd_en    = 1'b0;
        w_upd_key   = {KEY_WIDTH{1'b0}};
        w_upd_idx   = {INDEX_WIDTH{1'b0}};
        w_upd_valid = 1'b0;
        case (r_state)
            ST_EXEC: begin
                if (w_is_insert) begin
                    w_upd_en    = 1'b1;
                    w_upd_key   = r_key;
                    w_upd_idx   = w_tgt_idx;
                    w_upd_valid = 1'b1;
                end else if (w_is_inval_hit) begin
                    w_upd_en  = 1'b1;
                    w_upd_key = r_key;
                    w_upd_idx = cam_lookup_idx;
                end else begin
                    w_upd_en = 1'b0;
                end
            end
            ST_FLUSH: begin
                w_upd_en  = 1'b1;
                w_upd_idx = r_flush_cnt;
            end
            default: begin
                w_upd_en = 1'b0;
            end
        endcase
    end

    assign cam_update_en    = w_upd_en;
    assign cam_update_key   = w_upd_key;
    assign cam_update_idx   = w_upd_idx;
    assign cam_update_valid = w_upd_valid;
    assign cam_lookup_key   = r_key;
    assign req_ready        = r_ready;
    assign resp_valid       = r_resp_valid;
    assign resp_idx         = r_resp_idx;
    assign resp_hit         = r_resp_hit;
    assign resp_evict       = r_resp_evict;

    // Main sequencer, shadow valids and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_ready      <= 1'b1;
            r_op         <= 2'd0;
            r_key        <= {KEY_WIDTH{1'b0}};
            r_valid      <= {NUM_ENTRIES{1'b0}};
            r_flush_cnt  <= {INDEX_WIDTH{1'b0}};
            r_resp_valid <= 1'b0;
            r_resp_idx   <= {INDEX_WIDTH{1'b0}};
            r_resp_hit   <= 1'b0;
            r_resp_evict <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            if (w_upd_en) begin
                r_valid[w_upd_idx] <= w_upd_valid;
            end
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_op        <= req_op;
                        r_key       <= req_key;
                        r_ready     <= 1'b0;
                        r_flush_cnt <= {INDEX_WIDTH{1'b0}};
                        r_state     <= (req_op == 2'd2) ? ST_FLUSH : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_state      <= ST_IDLE;
                    r_ready      <= 1'b1;
                    r_resp_valid <= 1'b1;
                    r_resp_hit   <= (r_op == 2'd0 || r_op == 2'd1) && cam_lookup_hit;
                    r_resp_evict <= w_is_insert && w_evict;
                    r_resp_idx   <= w_is_insert    ? w_tgt_idx :
                                    w_is_inval_hit ? cam_lookup_idx : {INDEX_WIDTH{1'b0}};
                end
                ST_FLUSH: begin
                    r_flush_cnt <= r_flush_cnt + 1'b1;
                    if (r_flush_cnt == LAST_IDX) begin
                        r_state      <= ST_IDLE;
                        r_ready      <= 1'b1;
                        r_valid      <= {NUM_ENTRIES{1'b0}};
                        r_resp_valid <= 1'b1;
                        r_resp_hit   <= 1'b0;
                        r_resp_evict <= 1'b0;
                        r_resp_idx   <= {INDEX_WIDTH{1'b0}};
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_alloc_ctrl.sv
// Randomized bench for cam_alloc_ctrl with a behavioural CAM and a slot-level reference model.
module tb_cam_alloc_ctrl;
    localparam int N  = 4;
    localparam int KW = 32;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready;
    logic [1:0]    req_op;
    logic [KW-1:0] req_key;
    logic          resp_valid, resp_hit, resp_evict;
    logic [IW-1:0] resp_idx;
    logic [KW-1:0] cam_lookup_key;
    logic          cam_lookup_hit;
    logic [IW-1:0] cam_lookup_idx;
    logic          cam_update_en, cam_update_valid;
    logic [KW-1:0] cam_update_key;
    logic [IW-1:0] cam_update_idx;
    logic          touch_en;
    logic [IW-1:0] touch_idx;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cam_alloc_ctrl #(.NUM_ENTRIES(N), .KEY_WIDTH(KW), .INDEX_WIDTH(IW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_key(req_key),
        .resp_valid(resp_valid), .resp_idx(resp_idx), .resp_hit(resp_hit), .resp_evict(resp_evict),
        .cam_lookup_key(cam_lookup_key), .cam_lookup_hit(cam_lookup_hit), .cam_lookup_idx(cam_lookup_idx),
        .cam_update_en(cam_update_en), .cam_update_key(cam_update_key),
        .cam_update_idx(cam_update_idx), .cam_update_valid(cam_update_valid),
        .touch_en(touch_en), .touch_idx(touch_idx)
    );

    // Behavioural CAM attached to the controller
    logic [KW-1:0] cam_key [N];
    logic [N-1:0]  cam_v;

    always_comb begin
        cam_lookup_hit = 1'b0;
        cam_lookup_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cam_v[i] && cam_key[i] == cam_lookup_key) begin
                cam_lookup_hit = 1'b1;
                cam_lookup_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cam_v <= '0;
        end else if (cam_update_en) begin
            cam_v[cam_update_idx]   <= cam_update_valid;
            cam_key[cam_update_idx] <= cam_update_key;
        end
    end

    // Reference model: contents per slot, round-robin pointer, usage bits
    logic [KW-1:0] m_key [N];
    bit            m_v   [N];
    bit            m_used[N];
    int            m_rr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_v[i] = 1'b0;
            m_used[i] = 1'b0;
        end
        m_rr = 0;
    endtask

    task automatic model_use(input int s);
        bit all;
        m_used[s] = 1'b1;
        all = 1'b1;
        for (int i = 0; i < N; i++) all &= m_used[i];
        if (all) for (int i = 0; i < N; i++) m_used[i] = (i == s);
    endtask

    task automatic do_req(input logic [1:0] op, input logic [KW-1:0] key);
        int e_n, e_lat, e_ridx, got_n, w, tgt;
        bit e_hit, e_ev, done;
        int e_idx[N];
        bit e_val[N];
        logic [KW-1:0] e_key[N];
        e_n = 0; e_hit = 0; e_ev = 0; e_ridx = 0; e_lat = 2; tgt = -1;
        for (int i = 0; i < N; i++) if (tgt < 0 && m_v[i] && m_key[i] == key) tgt = i;
        case (op)
            2'd0: begin
                if (tgt >= 0) begin
                    e_hit = 1;
                end else begin
                    for (int i = N - 1; i >= 0; i--) if (!m_v[i]) tgt = i;
                    if (tgt < 0) begin
                        e_ev = 1;
`ifdef CAM_ALLOC_NRU_EN
                        tgt = 0;
                        for (int i = N - 1; i >= 0; i--) if (!m_used[i]) tgt = i;
`else
                        tgt = m_rr;
                        m_rr = (m_rr + 1) % N;
`endif
                    end
                end
                e_idx[0] = tgt; e_val[0] = 1; e_key[0] = key; e_n = 1; e_ridx = tgt;
                m_v[tgt] = 1; m_key[tgt] = key;
                model_use(tgt);
            end
            2'd1: begin
                if (tgt >= 0) begin
                    e_hit = 1; e_ridx = tgt;
                    e_idx[0] = tgt; e_val[0] = 0; e_key[0] = key; e_n = 1;
                    m_v[tgt] = 0; m_used[tgt] = 0;
                end
            end
            2'd2: begin
                for (int i = 0; i < N; i++) begin
                    e_idx[i] = i; e_val[i] = 0; e_key[i] = '0;
                end
                e_n = N; e_lat = N + 1;
                model_clear();
            end
            default: ;
        endcase
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1; req_op = op; req_key = key;
        @(posedge clk);
        #1 req_valid = 1'b0;
        got_n = 0; done = 0;
        for (int c = 1; c <= N + 4 && !done; c++) begin
            @(negedge clk);
            if (cam_update_en) begin
                if (got_n < e_n) begin
                    chk("upd_idx", cam_update_idx, e_idx[got_n]);
                    chk("upd_valid", cam_update_valid, e_val[got_n]);
                    chk("upd_key", cam_update_key, e_key[got_n]);
                end
                got_n++;
            end
            if (resp_valid) begin
                done = 1;
                chk("latency", c, e_lat);
                chk("resp_hit", resp_hit, e_hit);
                chk("resp_evict", resp_evict, e_ev);
                chk("resp_idx", resp_idx, e_ridx);
                chk("ready_at_resp", req_ready, 1'b1);
            end
        end
        chk("resp_seen", done, 1'b1);
        chk("upd_count", got_n, e_n);
    endtask

    task automatic do_touch(input int s);
        touch_en = 1'b1; touch_idx = IW'(s);
        @(posedge clk);
        #1 touch_en = 1'b0;
`ifdef CAM_ALLOC_NRU_EN
        model_use(s);
`endif
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_upd_en", cam_update_en, 1'b0);
        chk("rst_upd_idx", cam_update_idx, 2'd0);
        chk("rst_lookup_key", cam_lookup_key, 32'd0);
        reset = 1'b0;
        model_clear();
        @(negedge clk);
    endtask

    task automatic flush_with_reset();
        int upd = 0;
        bit resp_seen = 0;
        req_valid = 1'b1; req_op = 2'd2; req_key = '0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (cam_update_en) begin
                chk("pflush_idx", cam_update_idx, IW'(c));
                upd++;
            end
        end
        chk("pflush_updates", upd, 2);
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            if (resp_valid) resp_seen = 1;
            @(negedge clk);
        end
        chk("pflush_no_resp", resp_seen, 1'b0);
        chk("pflush_idle", req_ready, 1'b1);
    endtask

    initial begin
        int r;
        logic [1:0] op;
        logic [KW-1:0] key;
        reset = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_key = '0;
        touch_en = 1'b0; touch_idx = '0;
        @(negedge clk);
        apply_reset();
        chk("rst_resp_hit", resp_hit, 1'b0);
        chk("rst_resp_evict", resp_evict, 1'b0);
        chk("rst_resp_idx", resp_idx, 2'd0);

        do_req(2'd0, 32'h10); do_req(2'd0, 32'h20); do_req(2'd0, 32'h30);
        chk("plan_third_slot", resp_idx, 2'd2);
        do_req(2'd0, 32'h20);
        chk("plan_dup_slot", resp_idx, 2'd1);
        do_req(2'd1, 32'h30); do_req(2'd1, 32'h99);
        do_req(2'd0, 32'hA0);
        chk("plan_reuse_slot", resp_idx, 2'd2);
        do_req(2'd0, 32'h40);
`ifdef CAM_ALLOC_NRU_EN
        do_touch(0); do_touch(1); do_touch(3);
        do_req(2'd0, 32'h50);
        chk("plan_nru_victim", resp_idx, 2'd2);
        for (int i = 0; i < N; i++) do_touch(i);
        do_req(2'd0, 32'h60);
        chk("plan_nru_next", resp_idx, 2'd0);
`else
        for (int i = 0; i < 5; i++) do_req(2'd0, KW'(32'h50 + 32'h10 * i));
        chk("plan_rr_wrap", resp_idx, 2'd0);
`endif
        do_req(2'd3, 32'h77);
        do_req(2'd2, 32'h0);
        do_req(2'd0, 32'hB0);
        chk("plan_post_flush", resp_idx, 2'd0);
        do_req(2'd0, 32'hC0);
        flush_with_reset();
        do_req(2'd0, 32'hD0);
        chk("plan_post_reset", resp_idx, 2'd0);

        for (int t = 0; t < 250; t++) begin
            r = $urandom_range(0, 15);
            key = KW'(32'h10 * $urandom_range(1, 9));
            if (r < 2) begin
                do_touch($urandom_range(0, N - 1));
            end else begin
                op = (r < 9) ? 2'd0 : (r < 13) ? 2'd1 : (r < 14) ? 2'd2 : 2'd3;
                do_req(op, key);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cam_alloc_ctrl.md
# cam_alloc_ctrl

Sequencing controller for one `cam` instance. It accepts insert, invalidate and flush requests over a valid/ready handshake. It checks the CAM for an existing key before each write, so duplicates are never created. It picks the target slot (existing slot, then lowest free slot, then victim) and walks the table on flush. It sits between TLB/tag-management logic and the CAM update port, and is the only block that drives that port.

## Interface
- `NUM_ENTRIES`, 2: CAM entries, ≥2, any integer.
- `KEY_WIDTH`, 32: key width.
- `INDEX_WIDTH`, $clog2(NUM_ENTRIES): slot index width.

- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept; transfer on `req_valid && req_ready`.
- `req_op` in 2: 0 insert, 1 invalidate, 2 flush, 3 reserved (no-op).
- `req_key` in KEY_WIDTH: key for insert/invalidate.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_idx` out INDEX_WIDTH: slot written or found.
- `resp_hit` out 1: key was already present.
- `resp_evict` out 1: insert displaced a valid entry.
- `cam_lookup_key` out KEY_WIDTH: to CAM lookup port.
- `cam_lookup_hit` in 1: from CAM, same cycle.
- `cam_lookup_idx` in INDEX_WIDTH: from CAM, same cycle.
- `cam_update_en` out 1: to CAM update port.
- `cam_update_key` out KEY_WIDTH: to CAM update port.
- `cam_update_idx` out INDEX_WIDTH: to CAM update port.
- `cam_update_valid` out 1: to CAM update port.
- `touch_en` in 1: a lookup elsewhere hit `touch_idx`; used only with CAM_ALLOC_NRU_EN.
- `touch_idx` in INDEX_WIDTH: slot that was hit.

## Operation
- **States and transitions**
  - IDLE: `req_ready`=1. On transfer, latch op/key, then go to EXEC (op 0/1/3) or FLUSH (op 2).
  - EXEC: one cycle, then IDLE.
  - FLUSH: NUM_ENTRIES cycles, then IDLE.
- **Shadow state**
  - Shadow `valid[NUM_ENTRIES]` mirrors CAM entry valids; updated on every `cam_update_en`.
  - Round-robin `victim_ptr` is an INDEX_WIDTH register.
- **EXEC insert**
  - `cam_lookup_key` = latched key.
  - Target selection, in priority order:
    - hit: target = `cam_lookup_idx`, hit=1;
    - else any `valid`=0: target = lowest such index;
    - else target = victim, evict=1, and `victim_ptr` advances, wrapping from NUM_ENTRIES-1 to 0.
  - Drive `cam_update_en`=1, key = latched key, idx = target, valid=1.
- **EXEC invalidate**
  - On hit: write idx=`cam_lookup_idx`, valid=0, key=latched key; hit=1.
  - On miss: no update; hit=0; `resp_idx`=0.
- **EXEC op 3**: no update; respond with hit=0, evict=0, idx=0.
- **FLUSH**
  - Counter 0..NUM_ENTRIES-1; one update per cycle with idx=counter, valid=0, key=0.
  - Clears all shadow state.
  - Response: hit=0, evict=0, idx=0.
- **Outputs outside an update**: `cam_update_en`=0, `cam_update_key`=0, `cam_update_idx`=0, `cam_update_valid`=0. `cam_lookup_key` = latched key in all states.
- **Response registers**: `resp_*` are registered and valid only while `resp_valid`=1; they hold their last value otherwise.

## Timing
- Reset values:
  - state IDLE, `req_ready`=1;
  - `resp_valid`=`resp_hit`=`resp_evict`=0, `resp_idx`=0;
  - all `cam_update_*` 0, `cam_lookup_key`=0;
  - `valid`=0, `victim_ptr`=0, NRU bits 0, flush counter 0.
- The CAM's own reset must be asserted with `reset` so that shadow state and the CAM agree.
- Insert/invalidate:
  - request accepted at edge 0;
  - EXEC is the cycle after edge 0; update is committed at edge 1;
  - `resp_valid` is high the cycle after edge 1;
  - `req_ready` is high again in that same cycle. Back-to-back throughput is one request per 2 cycles.
- Flush:
  - accepted at edge 0; updates commit at edges 1..NUM_ENTRIES;
  - `resp_valid` is high the cycle after edge NUM_ENTRIES.
- The next EXEC lookup always sees the CAM state after the prior update (no same-cycle hazard).
- `reset` mid-EXEC or mid-FLUSH:
  - next cycle is IDLE; no response is issued;
  - any partial flush is abandoned, which is safe because the CAM is also reset.
- `req_valid` while `req_ready`=0 is ignored; the requester must hold the request.

## Configuration
- **`CAM_ALLOC_NRU_EN` defined**
  - Victim = lowest index whose `used` bit is 0, replacing `victim_ptr`, which is not instantiated.
  - A `used[i]` bit is set by `touch_en`, and by an insert targeting slot i.
  - If setting a bit would make all bits 1, all others are cleared in the same cycle.
  - Invalidate clears that slot's `used` bit; flush clears all `used` bits.
  - Touch and insert in the same cycle both apply.
- **`CAM_ALLOC_NRU_EN` undefined**
  - Round-robin `victim_ptr` is used.
  - `touch_en`/`touch_idx` are ignored.

## Test plan
- **Free-slot allocation**: after reset, NUM_ENTRIES=4, insert keys 0x10, 0x20, 0x30 → `resp_idx` 0, 1, 2; hit=0, evict=0; each response exactly 2 cycles after acceptance.
- **Duplicate insert**: insert 0x20 again → `resp_idx`=1, hit=1, one update at idx 1; no new slot consumed (the CAM duplicate check never fires).
- **Round-robin eviction** (macro off): fill 4 slots, then insert 0x50, 0x60, 0x70, 0x80, 0x90 → victims 0, 1, 2, 3, 0, each with evict=1.
- **Invalidate then insert**: invalidate 0x30 → hit=1, idx 2, CAM update valid=0; invalidate 0x99 → hit=0, no `cam_update_en`; then insert 0xA0 → idx 2, evict=0.
- **Flush and reset mid-flush**: flush → 4 consecutive updates, idx 0..3, valid=0; `resp_valid` 5 cycles after acceptance; next insert → idx 0. Repeat with `reset` after 2 updates → IDLE, no response, next insert → idx 0.
- **NRU victim** (macro on): fill 4 slots, touch 0, 1, 3 → insert new key evicts slot 2. Touching 0..3 clears all but slot 3, so the next victim is 0.
